// File: rtl/branch_predict_table_if.sv
// Pipeline-to-predictor bundle: decode lookup and execute training.
// master: pipeline drives pcs/outcomes; slave: predictor answers.
interface branch_predict_table_if;
  logic [31:0] pcD;
  logic        branchD;
  logic        brbitD;
  logic        updateE;
  logic [31:0] pcE;
  logic        takenE;
  logic        predE;
  logic        mispredictE;

  modport master (
    output pcD, branchD, updateE, pcE, takenE, predE,
    input  brbitD, mispredictE
  );

  modport slave (
    input  pcD, branchD, updateE, pcE, takenE, predE,
    output brbitD, mispredictE
  );
endinterface

// File: rtl/branch_predict_table.sv
// 2-bit saturating-counter branch predictor with perf counters.
// Ports: clk, reset (async low), clear, bus (slave), branch/mispred counts.
module branch_predict_table #(
  parameter int INDEX_BITS = 4,
  parameter int STAT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  branch_predict_table_if.slave bus,
  output logic [STAT_W-1:0] branchcount,
  output logic [STAT_W-1:0] mispredcount
);

  localparam int N = 1 << INDEX_BITS;

  logic [1:0]            r_tab [N];
  logic [STAT_W-1:0]     r_bc;
  logic [STAT_W-1:0]     r_mc;

  logic [INDEX_BITS-1:0] w_idxD;
  logic [INDEX_BITS-1:0] w_idxE;
  logic [1:0]            w_cur;
  logic [1:0]            w_nxt;
  logic                  w_mis;
  logic                  w_byp;
  logic                  w_unused;

  assign w_idxD = bus.pcD[INDEX_BITS+1:2];
  assign w_idxE = bus.pcE[INDEX_BITS+1:2];
  assign w_cur  = r_tab[w_idxE];

  always_comb begin
    w_nxt = w_cur;
    if (bus.takenE) begin
      if (w_cur != 2'b11) w_nxt = w_cur + 2'd1;
    end else begin
      if (w_cur != 2'b00) w_nxt = w_cur - 2'd1;
    end
  end

  assign w_mis = bus.updateE & (bus.takenE ^ bus.predE);

  // Forward the in-flight write so decode sees the fresh counter.
  assign w_byp = bus.updateE & ~clear & (w_idxE == w_idxD);

  assign bus.brbitD      = w_byp ? w_nxt[1] : r_tab[w_idxD][1];
  assign bus.mispredictE = w_mis;

  assign branchcount  = r_bc;
  assign mispredcount = r_mc;

  // branchD only qualifies the prediction downstream; high pc
  // bits alias by design.
  assign w_unused = ^{bus.branchD,
                      bus.pcD[31:INDEX_BITS+2], bus.pcD[1:0],
                      bus.pcE[31:INDEX_BITS+2], bus.pcE[1:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < N; i++) r_tab[i] <= 2'b01;
      r_bc <= '0;
      r_mc <= '0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) r_tab[i] <= 2'b01;
      r_bc <= '0;
      r_mc <= '0;
    end else if (bus.updateE) begin
      r_tab[w_idxE] <= w_nxt;
      if (r_bc != '1) r_bc <= r_bc + 1'b1;
      if (w_mis && (r_mc != '1)) r_mc <= r_mc + 1'b1;
    end
  end

endmodule

// File: doc/branch_predict_table.md
Name: branch_predict_table

Overview:
- Dynamic branch predictor for the pipelined MIPS core. Holds a direct-mapped table of 2-bit saturating counters indexed by PC bits.
- Read side: supplies the prediction bit brbitD to the decode-stage controller for the branch in decode.
- Write side: trains the indexed counter when a beq resolves in execute.
- Also keeps saturating branch and mispredict counters for performance measurement.

Parameters:
- INDEX_BITS, 4, log2 of table entries; index = pc[INDEX_BITS+1:2].
- STAT_W, 16, width of each statistics counter.

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- pcD  input  32  PC of the instruction in decode; lookup address.
- branchD  input  1  instruction in decode is a branch.
- brbitD  output  1  predicted taken (1) / not taken (0) for pcD.
- updateE  input  1  a branch resolves in execute this cycle.
- pcE  input  32  PC of the resolving branch.
- takenE  input  1  actual outcome of the resolving branch.
- predE  input  1  prediction originally given for that branch, carried down the pipe.
- clear  input  1  synchronous reinitialise of table and statistics.
- branchcount  output  STAT_W  resolved branches since reset/clear.
- mispredcount  output  STAT_W  mispredicted branches since reset/clear.
- mispredictE  output  1  combinational: updateE & (takenE != predE).

Behaviour:
- Table: 2^INDEX_BITS entries × 2 bits. Encoding: 00 strongly not-taken, 01 weakly not-taken, 10 weakly taken, 11 strongly taken.
- Reset (reset=0, asynchronous):
  - every entry = 01;
  - branchcount = 0, mispredcount = 0;
  - brbitD evaluates to 0.
- Lookup (combinational, zero latency): idxD = pcD[INDEX_BITS+1:2]; brbitD = entry[idxD][1].
  - brbitD is driven regardless of branchD; branchD is used only to qualify the output for downstream logic and may be left internally unused.
- Bypass: if updateE=1 and idxE == idxD in the same cycle, brbitD = MSB of the next-state value being written, not the stored value.
- Update (rising edge, updateE=1): idxE = pcE[INDEX_BITS+1:2].
  - takenE=1: entry increments, saturating at 11.
  - takenE=0: entry decrements, saturating at 00.
  - Only entry idxE changes; all others hold.
- Statistics (rising edge, updateE=1):
  - branchcount += 1;
  - mispredcount += 1 when takenE != predE;
  - both saturate at 2^STAT_W − 1 (no wrap).
- clear=1 (rising edge):
  - all entries go to 01 and both counters go to 0;
  - clear takes priority over a coincident update, whose effect is discarded;
  - bypass is inactive while clear=1, so brbitD reflects the stored value.
- PC bits [1:0] and bits above INDEX_BITS+1 are ignored (aliasing is accepted).
- Reset asserted mid-operation: immediate return to reset values regardless of clock.
- No handshake stalls: the block never back-pressures. The pipeline holds pcD stable during stalls; updateE must be pulsed for exactly one cycle per resolved branch, and the block does not detect duplicate pulses.

Test Plan:
1. Reset, then pcD=0x00000040 → brbitD=0; branchcount=0; mispredcount=0.
2. Two updates at pcE=0x40, takenE=1, predE=0 → entry[0]: 01→10→11; brbitD for pcD=0x40 becomes 1 after the first edge; mispredcount=2, branchcount=2. A third taken update keeps the entry at 11 (saturation).
3. Four not-taken updates at pcE=0x40 → entry 11→10→01→00→00; brbitD=0 after the second edge; pcD=0x44 (index 1) stays at 01 throughout.
4. Same-cycle bypass: entry[5]=01, pcD=pcE=0x14, updateE=1, takenE=1 → brbitD=1 in that same cycle, before the edge.
5. Aliasing and clear:
   - Update at pcE=0x400 (index 0, INDEX_BITS=4) also changes prediction for pcD=0x000.
   - clear=1 together with updateE=1 → after the edge all entries are 01 and both counters are 0.
6. Saturation and async reset, with STAT_W=4:
   - 20 mispredicted updates → branchcount=15, mispredcount=15;
   - assert reset between clock edges → counters read 0 immediately.
